// File: rtl/vote_session_ctrl.sv
// Three-judge majority-vote session controller: it arms a timed voting window on the
// start key, latches one sticky vote per judge, tallies 2-of-3 and holds the result on the LEDs.
module vote_session_ctrl #(
  parameter int WINDOW_CYCLES = 60_000_000,
  parameter int SHOW_CYCLES   = 36_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic [2:0] key_vote,
  output logic [2:0] num_led,
  output logic       result_led,
  output logic [1:0] vote_cnt,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYCLES = (WINDOW_CYCLES > SHOW_CYCLES) ? WINDOW_CYCLES : SHOW_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] WIN_LOAD  = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VOTE  = 2'd1;
  localparam logic [1:0] S_TALLY = 2'd2;
  localparam logic [1:0] S_SHOW  = 2'd3;

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_vote;
  logic          r_pass;
  logic [1:0]    r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [2:0]    r_num_led;

  logic          r_start_s1, r_start_s2, r_start_h;
  logic [2:0]    r_vote_s1, r_vote_s2, r_vote_h;

  logic          w_start_ev;
  logic [2:0]    w_vote_ev;
  logic [2:0]    w_vote_acc;
  logic [1:0]    w_tally;

  function automatic logic [1:0] f_popcnt(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Keys are active-low: a press is a synchronized high-to-low edge.
  assign w_start_ev = r_start_h & ~r_start_s2;
  assign w_vote_ev  = r_vote_h & ~r_vote_s2;
  assign w_vote_acc = r_vote | w_vote_ev;
  assign w_tally    = f_popcnt(r_vote);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_s1 <= 1'b1;
      r_start_s2 <= 1'b1;
      r_start_h  <= 1'b1;
      r_vote_s1  <= 3'b111;
      r_vote_s2  <= 3'b111;
      r_vote_h   <= 3'b111;
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_vote     <= 3'b000;
      r_pass     <= 1'b0;
      r_cnt      <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_num_led  <= 3'b111;
    end else begin
      r_start_s1 <= key_start;
      r_start_s2 <= r_start_s1;
      r_start_h  <= r_start_s2;
      r_vote_s1  <= key_vote;
      r_vote_s2  <= r_vote_s1;
      r_vote_h   <= r_vote_s2;
      r_done     <= 1'b0;

      if ((r_state == S_IDLE || r_state == S_SHOW) && w_start_ev) begin
        r_state   <= S_VOTE;
        r_timer   <= WIN_LOAD;
        r_vote    <= 3'b000;
        r_cnt     <= 2'd0;
        r_pass    <= 1'b0;
        r_busy    <= 1'b1;
        r_num_led <= 3'b111;
      end else begin
        case (r_state)
          S_VOTE: begin
            r_vote <= w_vote_acc;
            r_cnt  <= f_popcnt(w_vote_acc);
            // Early close looks at the registered votes, so it lands one cycle after the third vote.
            if (r_timer == '0 || &r_vote) begin
              r_state <= S_TALLY;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          S_TALLY: begin
            r_cnt     <= w_tally;
            r_pass    <= (w_tally >= 2'd2);
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_timer   <= SHOW_LOAD;
            r_num_led <= ~r_vote;
            r_state   <= S_SHOW;
          end
          S_SHOW: begin
            if (r_timer == '0) begin
              r_state   <= S_IDLE;
              r_pass    <= 1'b0;
              r_num_led <= 3'b111;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign num_led    = r_num_led;
  assign result_led = ~r_pass;
  assign vote_cnt   = r_cnt;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: table-driven sessions, directed corner sequences and random
// key activity, all checked every cycle against a session-timeline reference model.
module tb_vote_session_ctrl;
  localparam int W = 20;
  localparam int S = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b1;
  logic [2:0] key_vote = 3'b111;
  logic [2:0] num_led;
  logic       result_led;
  logic [1:0] vote_cnt;
  logic       busy;
  logic       done;

  vote_session_ctrl #(.WINDOW_CYCLES(W), .SHOW_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_vote(key_vote),
    .num_led(num_led), .result_led(result_led), .vote_cnt(vote_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Reference model: a session is described by its start edge e, its close edge tc
  // (timeout at e+W or one edge after the votes became full) and the accumulated votes.
  bit         ps1 = 1, ps2 = 1, ps3 = 1;
  logic [2:0] pv1 = 3'b111, pv2 = 3'b111, pv3 = 3'b111;
  bit         have_s = 0, tc_known = 0, full_known = 0;
  longint     e = 0, tc = 0, full_e = 0;
  logic [2:0] acc = 3'b000;
  bit         exp_busy = 0, exp_done = 0, exp_res = 1;
  logic [1:0] exp_cnt = 2'd0;
  logic [2:0] exp_leds = 3'b111;

  typedef struct {
    logic [2:0] press;
    logic [1:0] cnt;
    logic [2:0] leds;
    logic       res;
    bit         early;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit         evs;
    logic [2:0] evv;
    bit         close;
    bit         show;
    if (rst) begin
      ps1 = 1; ps2 = 1; ps3 = 1;
      pv1 = 3'b111; pv2 = 3'b111; pv3 = 3'b111;
      have_s = 0; tc_known = 0; full_known = 0; acc = 3'b000;
    end else begin
      evs = ps3 & ~ps2;
      evv = pv3 & ~pv2;
      ps3 = ps2; ps2 = ps1; ps1 = key_start;
      pv3 = pv2; pv2 = pv1; pv1 = key_vote;
      if (evs && (!have_s || (tc_known && cyc >= tc + 2))) begin
        have_s = 1; e = cyc; acc = 3'b000; tc_known = 0; full_known = 0;
      end else if (have_s && !tc_known) begin
        close = (cyc == e + W) || (full_known && cyc == full_e + 1);
        acc = acc | evv;
        if (acc == 3'b111 && !full_known) begin
          full_known = 1; full_e = cyc;
        end
        if (close) begin
          tc_known = 1; tc = cyc;
        end
      end
    end
    show     = have_s && tc_known && cyc >= tc + 1 && cyc <= tc + S;
    exp_busy = have_s && (!tc_known || cyc == tc);
    exp_done = have_s && tc_known && cyc == tc + 1;
    exp_cnt  = 2'($countones(acc));
    exp_leds = show ? ~acc : 3'b111;
    exp_res  = show ? !($countones(acc) >= 2) : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("vote_cnt", vote_cnt, exp_cnt);
    chk("num_led", num_led, exp_leds);
    chk("result_led", result_led, exp_res);
  endtask

  task automatic press_start();
    key_start = 1'b0;
    tick();
    key_start = 1'b1;
  endtask

  task automatic press_vote(input logic [2:0] mask);
    key_vote = ~mask;
    tick();
    key_vote = 3'b111;
  endtask

  task automatic wait_done(output longint dc);
    int n = 0;
    while (done !== 1'b1 && n < W + 20) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got no done pulse required within %0d cycles", W + 20);
    end
    dc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint k0, dc;
    int     seen;

    tbl[0] = '{press: 3'b101, cnt: 2'd2, leds: 3'b010, res: 1'b0, early: 1'b0};
    tbl[1] = '{press: 3'b010, cnt: 2'd1, leds: 3'b101, res: 1'b1, early: 1'b0};
    tbl[2] = '{press: 3'b111, cnt: 2'd3, leds: 3'b000, res: 1'b0, early: 1'b1};
    tbl[3] = '{press: 3'b000, cnt: 2'd0, leds: 3'b111, res: 1'b1, early: 1'b0};
    tbl[4] = '{press: 3'b110, cnt: 2'd2, leds: 3'b001, res: 1'b0, early: 1'b0};
    tbl[5] = '{press: 3'b001, cnt: 2'd1, leds: 3'b110, res: 1'b1, early: 1'b0};

    repeat (3) tick();
    chk("rst_num_led", num_led, 3'b111);
    chk("rst_result_led", result_led, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vote_cnt", vote_cnt, 2'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      press_start();
      k0 = cyc;
      repeat (3) tick();
      if (tbl[i].press != 3'b000) press_vote(tbl[i].press);
      wait_done(dc);
      chk("tbl_vote_cnt", vote_cnt, tbl[i].cnt);
      chk("tbl_num_led", num_led, tbl[i].leds);
      chk("tbl_result_led", result_led, tbl[i].res);
      if (tbl[i].early) begin
        checks++;
        if (!(dc - k0 < W + 3)) begin
          errors++;
          $display("FAIL early_close: latency %0d required below %0d", dc - k0, W + 3);
        end
      end else begin
        chk("tbl_latency", 32'(dc - k0), W + 3);
      end
      repeat (S + 3) tick();
      chk("idle_num_led", num_led, 3'b111);
      chk("idle_result_led", result_led, 1'b1);
      chk("idle_vote_cnt_kept", vote_cnt, tbl[i].cnt);
    end

    // Vote event on the final window cycle is counted.
    press_start();
    repeat (W - 1) tick();
    press_vote(3'b100);
    wait_done(dc);
    chk("edge_in_cnt", vote_cnt, 2'd1);
    chk("edge_in_led", num_led, 3'b011);
    repeat (S + 3) tick();

    // Vote event one cycle later lands in TALLY and is dropped.
    press_start();
    repeat (W) tick();
    press_vote(3'b010);
    wait_done(dc);
    chk("edge_out_cnt", vote_cnt, 2'd0);
    chk("edge_out_led", num_led, 3'b111);
    repeat (S + 3) tick();

    // Sticky vote with a long hold, a repeat press and an ignored restart.
    press_start();
    k0 = cyc;
    repeat (2) tick();
    key_vote = 3'b011;
    repeat (5) tick();
    key_vote = 3'b111;
    repeat (2) tick();
    press_vote(3'b100);
    repeat (2) tick();
    press_start();
    wait_done(dc);
    chk("sticky_cnt", vote_cnt, 2'd1);
    chk("sticky_latency", 32'(dc - k0), W + 3);

    // Start during SHOW begins a fresh session at once.
    tick();
    press_start();
    repeat (2) tick();
    chk("restart_busy", busy, 1'b1);
    chk("restart_cnt", vote_cnt, 2'd0);
    chk("restart_led", num_led, 3'b111);
    wait_done(dc);
    repeat (S + 3) tick();

    // Reset in the middle of VOTE discards the session.
    press_start();
    repeat (3) tick();
    press_vote(3'b001);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_cnt", vote_cnt, 2'd0);
    chk("async_rst_led", num_led, 3'b111);
    chk("async_rst_res", result_led, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    seen = 0;
    repeat (W + S + 5) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Random key activity with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      key_start = ($urandom_range(0, 29) != 0);
      for (int b = 0; b < 3; b++) key_vote[b] = ($urandom_range(0, 5) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    key_start = 1'b1;
    key_vote = 3'b111;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
